collision_ctrl: RTL and testbench

COLLISION_CTRL -- requirements
Module: collision_ctrl

---
 rtl/collision_ctrl.sv | 163 ++++++++++++++++
 tb/tb_collision_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/collision_ctrl.sv
// Pong collision controller: wall, paddle and miss detection with lockout.
// Optional scoring and PLAY/OVER machine enabled by COLLISION_SCORE_EN.
module collision_ctrl #(
    parameter int BALL_SIZE  = 8,
    parameter int PAD_H      = 64,
    parameter int PAD_X_L    = 16,
    parameter int PAD_X_R    = 616,
    parameter int LOCK_STEPS = 4,
    parameter int WIN_SCORE  = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [9:0] xCoord,
    input  logic [8:0] yCoord,
    input  logic [8:0] leftPadY,
    input  logic [8:0] rightPadY,
    output logic       vCol,
    output logic       hCol,
    output logic       miss,
    output logic [3:0] scoreL,
    output logic [3:0] scoreR,
    output logic       gameOver
);

    localparam int CW = (LOCK_STEPS < 1) ? 1 : $clog2(LOCK_STEPS + 1);
    localparam logic [CW-1:0] LOCK = CW'(LOCK_STEPS);

    localparam logic [10:0] BS    = 11'(BALL_SIZE);
    localparam logic [10:0] PH    = 11'(PAD_H);
    localparam logic [10:0] LX_LO = 11'(PAD_X_L);
    localparam logic [10:0] LX_HI = 11'(PAD_X_L + 8);
    localparam logic [10:0] RX_LO = 11'(PAD_X_R);
    localparam logic [10:0] RX_HI = 11'(PAD_X_R + 8);
    localparam logic [10:0] Y_BOT = 11'(480 - BALL_SIZE);
    localparam logic [10:0] X_RGT = 11'(640 - BALL_SIZE);

    logic [10:0] x;
    logic [10:0] y;
    logic [10:0] lp;
    logic [10:0] rp;

    assign x  = {1'b0, xCoord};
    assign y  = {2'b00, yCoord};
    assign lp = {2'b00, leftPadY};
    assign rp = {2'b00, rightPadY};

    logic v_hit;
    logic l_pad;
    logic r_pad;
    logic l_miss;
    logic r_miss;

    // Geometry tests, all widened so no sum can wrap
    always_comb begin
        v_hit  = (y == 11'd0) || (y >= Y_BOT);
        l_pad  = (x <= LX_HI) && (x + BS > LX_LO) &&
                 (y + BS > lp) && (y < lp + PH);
        r_pad  = (x <= RX_HI) && (x + BS > RX_LO) &&
                 (y + BS > rp) && (y < rp + PH);
        l_miss = (x == 11'd0);
        r_miss = (x >= X_RGT);
    end

    logic          play;
    logic [CW-1:0] v_lock;
    logic [CW-1:0] h_lock;
    logic          eval;
    logic          h_ok;
    logic          v_fire;
    logic          h_fire;
    logic          l_fire;
    logic          r_fire;

    assign eval   = enable & play;
    assign h_ok   = eval & (h_lock == '0);
    assign v_fire = eval & v_hit & (v_lock == '0);
    assign l_fire = h_ok & l_miss;
    assign r_fire = h_ok & r_miss;
    assign h_fire = h_ok & (l_miss | r_miss | l_pad | r_pad);

    // Registered bounce pulses and per-axis lockout counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vCol   <= 1'b0;
            hCol   <= 1'b0;
            miss   <= 1'b0;
            v_lock <= '0;
            h_lock <= '0;
        end else begin
            vCol <= v_fire;
            hCol <= h_fire;
            miss <= l_fire | r_fire;
            if (enable) begin
                if (v_fire)
                    v_lock <= LOCK;
                else if (v_lock != '0)
                    v_lock <= v_lock - CW'(1);
                if (h_fire)
                    h_lock <= LOCK;
                else if (h_lock != '0)
                    h_lock <= h_lock - CW'(1);
            end
        end
    end

`ifdef COLLISION_SCORE_EN
    localparam logic [3:0] WIN = 4'(WIN_SCORE);

    typedef enum logic {PLAY, OVER} state_t;

    state_t     state;
    logic [3:0] sl;
    logic [3:0] sr;
    logic       over;

    assign play     = (state == PLAY);
    assign scoreL   = sl;
    assign scoreR   = sr;
    assign gameOver = over;

    // Score keeping and PLAY/OVER machine; OVER exits only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= PLAY;
            sl    <= 4'd0;
            sr    <= 4'd0;
            over  <= 1'b0;
        end else begin
            case (state)
                PLAY: begin
                    if (r_fire && sl != WIN) begin
                        sl <= sl + 4'd1;
                        if (sl + 4'd1 == WIN) begin
                            state <= OVER;
                            over  <= 1'b1;
                        end
                    end
                    if (l_fire && sr != WIN) begin
                        sr <= sr + 4'd1;
                        if (sr + 4'd1 == WIN) begin
                            state <= OVER;
                            over  <= 1'b1;
                        end
                    end
                end
                OVER: begin
                    over <= 1'b1;
                end
            endcase
        end
    end
`else
    logic unused_win;

    assign unused_win = (WIN_SCORE != 0);
    assign play       = 1'b1;
    assign scoreL     = 4'd0;
    assign scoreR     = 4'd0;
    assign gameOver   = 1'b0;
`endif

endmodule

// File: tb/tb_collision_ctrl.sv
// Directed table-driven bench for collision_ctrl.
// Score expectations follow COLLISION_SCORE_EN.
module tb_collision_ctrl;

`ifdef COLLISION_SCORE_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [9:0] xCoord = 10'd300;
    logic [8:0] yCoord = 9'd200;
    logic [8:0] leftPadY = 9'd200;
    logic [8:0] rightPadY = 9'd200;
    logic       vCol;
    logic       hCol;
    logic       miss;
    logic [3:0] scoreL;
    logic [3:0] scoreR;
    logic       gameOver;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    collision_ctrl dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .xCoord(xCoord),
        .yCoord(yCoord),
        .leftPadY(leftPadY),
        .rightPadY(rightPadY),
        .vCol(vCol),
        .hCol(hCol),
        .miss(miss),
        .scoreL(scoreL),
        .scoreR(scoreR),
        .gameOver(gameOver)
    );

    typedef struct {
        logic en;
        int   x;
        int   y;
        int   lp;
        int   rp;
        logic v;
        logic h;
        logic m;
        string nm;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic en, input int x, input int y,
                        input int lp, input int rp, input logic ev,
                        input logic eh, input logic em, input string nm);
        enable    = en;
        xCoord    = 10'(x);
        yCoord    = 9'(y);
        leftPadY  = 9'(lp);
        rightPadY = 9'(rp);
        @(posedge clk);
        @(negedge clk);
        chk({nm, "_vCol"}, int'(vCol), int'(ev));
        chk({nm, "_hCol"}, int'(hCol), int'(eh));
        chk({nm, "_miss"}, int'(miss), int'(em));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b1, 300, 200, 200, 200, 1'b0, 1'b0, 1'b0, "idle");
    endtask

    task automatic add(input logic en, input int x, input int y,
                       input int lp, input int rp, input logic v,
                       input logic h, input logic m, input string nm);
        vec_t r;
        r.en = en; r.x = x; r.y = y; r.lp = lp; r.rp = rp;
        r.v = v; r.h = h; r.m = m; r.nm = nm;
        tv.push_back(r);
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++)
            add(1'b1, 300, 200, 200, 200, 1'b0, 1'b0, 1'b0, "idle");
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_vCol"}, int'(vCol), 0);
        chk({nm, "_hCol"}, int'(hCol), 0);
        chk({nm, "_miss"}, int'(miss), 0);
        chk({nm, "_scoreL"}, int'(scoreL), 0);
        chk({nm, "_scoreR"}, int'(scoreR), 0);
        chk({nm, "_gameOver"}, int'(gameOver), 0);
    endtask

    initial begin
        // top wall and vertical lockout, including hold while enable=0
        add(1, 300, 0, 200, 200, 1, 0, 0, "top_hit");
        add(1, 300, 0, 200, 200, 0, 0, 0, "top_lock1");
        add(1, 300, 0, 200, 200, 0, 0, 0, "top_lock2");
        add(1, 300, 0, 200, 200, 0, 0, 0, "top_lock3");
        add(1, 300, 0, 200, 200, 0, 0, 0, "top_lock4");
        add(1, 300, 0, 200, 200, 1, 0, 0, "top_rehit");
        add(0, 300, 0, 200, 200, 0, 0, 0, "en_off");
        add_idle(3);
        add(1, 300, 0, 200, 200, 0, 0, 0, "held_lock");
        add(1, 300, 0, 200, 200, 1, 0, 0, "after_hold");
        add_idle(4);
        // left paddle
        add(1, 24, 100, 80, 200, 0, 1, 0, "lpad_hit");
        add_idle(4);
        add(1, 24, 100, 200, 200, 0, 0, 0, "lpad_missy");
        add(1, 25, 100, 80, 200, 0, 0, 0, "lpad_x25");
        add(1, 9, 100, 80, 200, 0, 1, 0, "lpad_x9");
        add_idle(4);
        add(1, 20, 72, 80, 200, 0, 0, 0, "lpad_y72");
        add(1, 20, 143, 80, 200, 0, 1, 0, "lpad_y143");
        add_idle(4);
        // bottom wall boundary
        add(1, 300, 472, 200, 200, 1, 0, 0, "bot_472");
        add_idle(4);
        add(1, 300, 471, 200, 200, 0, 0, 0, "bot_471");
        // right wall and right paddle
        add(1, 632, 200, 200, 200, 0, 1, 1, "rwall_632");
        add_idle(4);
        add(1, 631, 200, 200, 200, 0, 0, 0, "rwall_631");
        add(1, 608, 200, 200, 200, 0, 0, 0, "rpad_608");
        add(1, 609, 200, 200, 200, 0, 1, 0, "rpad_609");
        add_idle(4);
        // corner: both axes at once, then horizontal lockout on a miss
        add(1, 0, 0, 200, 200, 1, 1, 1, "corner");
        add(1, 0, 200, 200, 200, 0, 0, 0, "miss_locked");
        add_idle(3);
        add(1, 0, 200, 200, 200, 0, 1, 1, "lwall");
        add_idle(4);

        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b1;

        for (int i = 0; i < tv.size(); i++)
            step(tv[i].en, tv[i].x, tv[i].y, tv[i].lp, tv[i].rp,
                 tv[i].v, tv[i].h, tv[i].m, tv[i].nm);

        chk("tbl_scoreL", int'(scoreL), SC ? 1 : 0);
        chk("tbl_scoreR", int'(scoreR), SC ? 2 : 0);
        chk("tbl_gameOver", int'(gameOver), 0);

        // reset mid-lockout with a pulse on the outputs
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1, 632, 200, 200, 200, 0, 1, 1, "pre_miss");
            idle(4);
        end
        chk("pre_scoreL", int'(scoreL), SC ? 5 : 0);
        step(1, 300, 0, 200, 200, 1, 0, 0, "pre_top");
        #2 reset = 1'b0;
        #1 chk_all_zero("async_rst");
        @(negedge clk);
        enable = 1'b0;
        reset  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("post_rel");
        step(1, 300, 0, 200, 200, 1, 0, 0, "rel_top");
        idle(4);

        // nine right-wall misses end the game when scoring is on
        for (int i = 0; i < 9; i++) begin
            step(1, 632, 200, 200, 200, 0, 1, 1, "win_miss");
            if (i < 8) idle(4);
        end
        chk("win_gameOver", int'(gameOver), SC ? 1 : 0);
        idle(4);
        chk("win_scoreL", int'(scoreL), SC ? 9 : 0);
        chk("win_scoreR", int'(scoreR), 0);
        step(1, 632, 0, 200, 200, !SC, !SC, !SC, "over_hit");
        chk("over_level", int'(gameOver), SC ? 1 : 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
